// File: rtl/core_pkg.sv
// Shared types and helpers for the vector register file access path.
// Sizes here describe a 32-register VRF of 64-byte registers in 8-byte words.
package core_pkg;

  localparam int VRFWordB   = 8;
  localparam int VLenB      = 64;
  localparam int NrVRegs    = 32;
  localparam int NrOpQueues = 2;

  localparam int VRegWords = VLenB / VRFWordB;
  localparam int AddrW     = $clog2(NrVRegs * VRegWords);

  typedef logic [$clog2(NrVRegs)-1:0] vreg_t;
  typedef logic [AddrW-1:0]           vrf_addr_t;
  typedef logic [8*VRFWordB-1:0]      vrf_data_t;
  typedef logic [7:0]                 vlen_t;

  localparam int WCntW = $bits(vlen_t) + 1 - $clog2(VRFWordB);
  typedef logic [WCntW-1:0] wcnt_t;

  typedef enum logic {
    Idle,
    Busy
  } req_state_e;

  typedef struct packed {
    vreg_t      vs1;
    vreg_t      vs2;
    logic [1:0] queue_req;
    vlen_t      vlB;
  } op_req_t;

  // First word address of a vector register.
  function automatic vrf_addr_t GetVRFAddr(input vreg_t vreg);
    return vrf_addr_t'(vreg) * vrf_addr_t'(VRegWords);
  endfunction

  // Number of VRF words covering vl bytes, rounded up.
  function automatic wcnt_t GetNrWords(input vlen_t vl);
    logic [$bits(vlen_t):0] s;
    s = {1'b0, vl} + ($bits(vlen_t)+1)'(VRFWordB - 1);
    return wcnt_t'(s >> $clog2(VRFWordB));
  endfunction

endpackage

// File: rtl/operand_fifo.sv
// Operand word buffer: synchronous FIFO with a registered fill count,
// which the requester uses as read credit.
module operand_fifo #(
  parameter int Depth = 4,
  parameter int Width = 65
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [Width-1:0]             push_data,
  input  logic                         pop,
  output logic                         valid,
  output logic [Width-1:0]             head,
  output logic [$clog2(Depth+1)-1:0]   count
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_q;
  logic [PtrW-1:0]  rd_q;
  logic             do_pop;

  assign valid  = count != '0;
  assign do_pop = pop && valid;
  assign head   = mem[rd_q];

  function automatic logic [PtrW-1:0] wrap(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage carries no reset; an empty count masks stale entries.
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= push_data;
  end

  // Pointers and fill count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      count <= '0;
    end else begin
      if (push)   wr_q <= wrap(wr_q);
      if (do_pop) rd_q <= wrap(rd_q);
      count <= count + CntW'(push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/operand_requester.sv
// Reads vs1/vs2 words from the VRF for one launched request at a time
// and feeds them in order into operand queues A and B.
module operand_requester
  import core_pkg::*;
#(
  parameter int QueueDepth = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         op_req_valid_i,
  output logic                         op_req_ready_o,
  input  op_req_t                      op_req_i,
  output logic                         vrf_rd_valid_o,
  input  logic                         vrf_rd_ready_i,
  output vrf_addr_t                    vrf_rd_addr_o,
  input  vrf_data_t                    vrf_rd_data_i,
  output logic [NrOpQueues-1:0]        opq_valid_o,
  input  logic [NrOpQueues-1:0]        opq_ready_i,
  output vrf_data_t [NrOpQueues-1:0]   opq_data_o,
  output logic [NrOpQueues-1:0]        opq_last_o
);

  localparam int CntW = $clog2(QueueDepth + 1);
  localparam int EntW = $bits(vrf_data_t) + 1;

  req_state_e state_q;
  vrf_addr_t  base_q [NrOpQueues];
  wcnt_t      rem_q  [NrOpQueues];
  wcnt_t      idx_q  [NrOpQueues];
  logic       ptr_q;
  logic       pend_q;
  logic       pend_sel_q;
  logic       ret_valid_q;
  logic       ret_tag_q;
  logic       ret_last_q;

  logic [CntW-1:0]       occ   [NrOpQueues];
  logic [CntW:0]         load  [NrOpQueues];
  logic [EntW-1:0]       head  [NrOpQueues];
  logic [NrOpQueues-1:0] fvalid;
  logic [NrOpQueues-1:0] push;
  logic [NrOpQueues-1:0] elig;
  logic                  sel;
  logic                  acc;
  logic                  done;

  assign op_req_ready_o = state_q == Idle;

  // Credit check, arbitration and the VRF read request.
  always_comb begin
    elig = '0;
    for (int q = 0; q < NrOpQueues; q++) begin
      load[q] = {1'b0, occ[q]}
              + (CntW+1)'(ret_valid_q && (ret_tag_q == q[0]));
      elig[q] = (state_q == Busy) && (rem_q[q] != '0)
              && (load[q] < (CntW+1)'(QueueDepth));
    end
    if (pend_q)            sel = pend_sel_q;
    else if (elig[ptr_q])  sel = ptr_q;
    else                   sel = ~ptr_q;
    vrf_rd_valid_o = pend_q || (|elig);
    vrf_rd_addr_o  = base_q[sel] + vrf_addr_t'(idx_q[sel]);
    acc  = vrf_rd_valid_o && vrf_rd_ready_i;
    done = 1'b1;
    for (int q = 0; q < NrOpQueues; q++) begin
      if (rem_q[q] != wcnt_t'(acc && (sel == q[0]))) done = 1'b0;
    end
  end

  // Request FSM, read bookkeeping and the 1-deep return register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= Idle;
      ptr_q       <= 1'b0;
      pend_q      <= 1'b0;
      pend_sel_q  <= 1'b0;
      ret_valid_q <= 1'b0;
      ret_tag_q   <= 1'b0;
      ret_last_q  <= 1'b0;
      for (int q = 0; q < NrOpQueues; q++) begin
        base_q[q] <= '0;
        rem_q[q]  <= '0;
        idx_q[q]  <= '0;
      end
    end else begin
      ret_valid_q <= acc;
      ret_tag_q   <= sel;
      ret_last_q  <= rem_q[sel] == wcnt_t'(1);
      unique case (state_q)
        Idle: begin
          if (op_req_valid_i) begin
            base_q[0] <= GetVRFAddr(op_req_i.vs1);
            base_q[1] <= GetVRFAddr(op_req_i.vs2);
            for (int q = 0; q < NrOpQueues; q++) begin
              rem_q[q] <= op_req_i.queue_req[q]
                        ? GetNrWords(op_req_i.vlB) : '0;
              idx_q[q] <= '0;
            end
            ptr_q   <= 1'b0;
            pend_q  <= 1'b0;
            state_q <= Busy;
          end
        end
        Busy: begin
          if (acc) begin
            rem_q[sel] <= rem_q[sel] - 1'b1;
            idx_q[sel] <= idx_q[sel] + 1'b1;
            ptr_q      <= ~sel;
          end
          pend_q     <= vrf_rd_valid_o && !vrf_rd_ready_i;
          pend_sel_q <= sel;
          if (done) state_q <= Idle;
        end
        default: state_q <= Idle;
      endcase
    end
  end

  // Returned words land in the queue named by the tag.
  always_comb begin
    for (int q = 0; q < NrOpQueues; q++) begin
      push[q]          = ret_valid_q && (ret_tag_q == q[0]);
      opq_valid_o[q]   = fvalid[q];
      opq_last_o[q]    = fvalid[q] && head[q][EntW-1];
      opq_data_o[q]    = head[q][EntW-2:0];
    end
  end

  for (genvar q = 0; q < NrOpQueues; q++) begin : g_opq
    operand_fifo #(
      .Depth (QueueDepth),
      .Width (EntW)
    ) i_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (push[q]),
      .push_data ({ret_last_q, vrf_rd_data_i}),
      .pop       (opq_ready_i[q]),
      .valid     (fvalid[q]),
      .head      (head[q]),
      .count     (occ[q])
    );
  end

endmodule

// File: tb/tb_operand_requester.sv
// Directed bench for operand_requester: VRF model returns a word derived
// from its address, a negedge monitor logs reads, stalls and queue pops.
module tb_operand_requester;
  import core_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       op_req_valid = 1'b0;
  logic                       op_req_ready;
  op_req_t                    op_req = '0;
  logic                       vrf_rd_valid;
  logic                       vrf_rd_ready = 1'b1;
  vrf_addr_t                  vrf_rd_addr;
  vrf_data_t                  vrf_rd_data = '0;
  logic [NrOpQueues-1:0]      opq_valid;
  logic [NrOpQueues-1:0]      opq_ready = '0;
  vrf_data_t [NrOpQueues-1:0] opq_data;
  logic [NrOpQueues-1:0]      opq_last;

  operand_requester #(.QueueDepth(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .op_req_valid_i (op_req_valid),
    .op_req_ready_o (op_req_ready),
    .op_req_i       (op_req),
    .vrf_rd_valid_o (vrf_rd_valid),
    .vrf_rd_ready_i (vrf_rd_ready),
    .vrf_rd_addr_o  (vrf_rd_addr),
    .vrf_rd_data_i  (vrf_rd_data),
    .opq_valid_o    (opq_valid),
    .opq_ready_i    (opq_ready),
    .opq_data_o     (opq_data),
    .opq_last_o     (opq_last)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit tog   = 1'b0;

  vrf_addr_t   acc_addr [$];
  int          acc_cyc  [$];
  logic [64:0] got0 [$];
  logic [64:0] got1 [$];
  int          pcyc0 [$];
  bit          ready_log [4096];
  int          vcnt, stall_cnt, stall_err;
  bit          was_stalled;
  vrf_addr_t   stall_addr;
  bit          acc_pend = 1'b0;
  vrf_addr_t   addr_pend = '0;

  function automatic vrf_data_t mk(input vrf_addr_t a);
    return 64'hF00D_0000_0000_0000 | vrf_data_t'(a);
  endfunction

  function automatic logic [64:0] ew(input int a, input bit last);
    return {last, mk(vrf_addr_t'(a))};
  endfunction

  task automatic chk(input string tag, input logic [71:0] got,
                     input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (tog) vrf_rd_ready = ~vrf_rd_ready;
    end
  endtask

  task automatic clr();
    acc_addr.delete();
    acc_cyc.delete();
    got0.delete();
    got1.delete();
    pcyc0.delete();
    vcnt = 0;
    stall_cnt = 0;
    stall_err = 0;
  endtask

  task automatic send(input int a, input int b, input logic [1:0] qr,
                      input int vl, output int hs);
    op_req.vs1       = vreg_t'(a);
    op_req.vs2       = vreg_t'(b);
    op_req.queue_req = qr;
    op_req.vlB       = vlen_t'(vl);
    op_req_valid     = 1'b1;
    for (int k = 0; k < 64 && !op_req_ready; k++) tick(1);
    chk("req_ready_wait", op_req_ready, 1);
    hs = cyc;
    tick(1);
    op_req_valid = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  // VRF model: data for the read accepted in the previous cycle.
  always @(posedge clk) begin
    #1;
    vrf_rd_data = acc_pend ? mk(addr_pend) : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  // Monitor sampling mid-cycle.
  always @(negedge clk) begin
    acc_pend = 1'b0;
    if (rst) begin
      was_stalled = 1'b0;
    end else begin
      if (vrf_rd_valid) vcnt++;
      if (vrf_rd_valid && vrf_rd_ready) begin
        acc_pend  = 1'b1;
        addr_pend = vrf_rd_addr;
        acc_addr.push_back(vrf_rd_addr);
        acc_cyc.push_back(cyc);
      end
      if (was_stalled) begin
        stall_cnt++;
        if (!vrf_rd_valid || vrf_rd_addr != stall_addr) stall_err++;
      end
      was_stalled = vrf_rd_valid && !vrf_rd_ready;
      stall_addr  = vrf_rd_addr;
      if (opq_valid[0] && opq_ready[0]) begin
        got0.push_back({opq_last[0], opq_data[0]});
        pcyc0.push_back(cyc);
      end
      if (opq_valid[1] && opq_ready[1])
        got1.push_back({opq_last[1], opq_data[1]});
      ready_log[cyc % 4096] = op_req_ready;
    end
  end

  initial begin
    int h, h2;
    clr();
    tick(3);
    chk("rst_ready", op_req_ready, 1);
    chk("rst_rd_valid", vrf_rd_valid, 0);
    chk("rst_opq_valid", opq_valid, 0);
    chk("rst_opq_last", opq_last, 0);
    rst = 1'b0;
    tick(2);

    // Both operands, two words each, interleaved.
    clr();
    opq_ready = 2'b11;
    send(3, 5, 2'b11, 16, h);
    tick(10);
    chk("t1_nreads", acc_addr.size(), 4);
    chk("t1_addr0", acc_addr[0], 24);
    chk("t1_addr1", acc_addr[1], 40);
    chk("t1_addr2", acc_addr[2], 25);
    chk("t1_addr3", acc_addr[3], 41);
    chk("t1_first_rd_cyc", acc_cyc[0], h + 1);
    chk("t1_last_rd_cyc", acc_cyc[3], h + 4);
    chk("t1_ready_busy", ready_log[(h + 4) % 4096], 0);
    chk("t1_ready_back", ready_log[(h + 5) % 4096], 1);
    chk("t1_a_cnt", got0.size(), 2);
    chk("t1_a0", got0[0], ew(24, 0));
    chk("t1_a1", got0[1], ew(25, 1));
    chk("t1_b_cnt", got1.size(), 2);
    chk("t1_b0", got1[0], ew(40, 0));
    chk("t1_b1", got1[1], ew(41, 1));
    chk("t1_a_head_cyc", pcyc0[0], h + 3);

    // Zero-length request.
    clr();
    send(3, 5, 2'b11, 0, h);
    tick(6);
    chk("t2_valid_cycles", vcnt, 0);
    chk("t2_pops", got0.size() + got1.size(), 0);
    chk("t2_ready_low", ready_log[(h + 1) % 4096], 0);
    chk("t2_ready_high", ready_log[(h + 2) % 4096], 1);

    // Queue B back-pressured: credit stops issue after four reads.
    clr();
    opq_ready = 2'b00;
    send(1, 7, 2'b10, 40, h);
    tick(12);
    chk("t3_stall_reads", acc_addr.size(), 4);
    chk("t3_opq_valid", opq_valid, 2'b10);
    chk("t3_ready_busy", op_req_ready, 0);
    opq_ready = 2'b10;
    tick(1);
    opq_ready = 2'b00;
    tick(6);
    chk("t3_after_pop_reads", acc_addr.size(), 5);
    chk("t3_addr4", acc_addr[4], 60);
    opq_ready = 2'b11;
    tick(10);
    chk("t3_b_cnt", got1.size(), 5);
    chk("t3_b0", got1[0], ew(56, 0));
    chk("t3_b3", got1[3], ew(59, 0));
    chk("t3_b4", got1[4], ew(60, 1));
    chk("t3_a_cnt", got0.size(), 0);

    // VRF ready toggling: held address across stalls.
    clr();
    tog = 1'b1;
    vrf_rd_ready = 1'b0;
    send(2, 0, 2'b01, 24, h);
    tick(16);
    tog = 1'b0;
    vrf_rd_ready = 1'b1;
    tick(2);
    chk("t4_stalls_seen", stall_cnt > 0, 1);
    chk("t4_addr_stable", stall_err, 0);
    chk("t4_a_cnt", got0.size(), 3);
    chk("t4_a0", got0[0], ew(16, 0));
    chk("t4_a1", got0[1], ew(17, 0));
    chk("t4_a2", got0[2], ew(18, 1));

    // Back-to-back single-word requests.
    clr();
    send(1, 0, 2'b01, 8, h);
    send(4, 0, 2'b01, 8, h2);
    tick(8);
    chk("t5_second_hs", h2, acc_cyc[0] + 1);
    chk("t5_a_cnt", got0.size(), 2);
    chk("t5_a0", got0[0], ew(8, 1));
    chk("t5_a1", got0[1], ew(32, 1));

    // Reset in the middle of a request.
    clr();
    send(6, 9, 2'b11, 16, h);
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("t6_rst_ready", op_req_ready, 1);
    chk("t6_rst_rd_valid", vrf_rd_valid, 0);
    chk("t6_rst_opq_valid", opq_valid, 0);
    chk("t6_rst_opq_last", opq_last, 0);
    chk("t6_reads_before", acc_addr.size(), 2);
    rst = 1'b0;
    tick(2);
    clr();
    send(10, 0, 2'b01, 16, h);
    tick(8);
    chk("t6_a_cnt", got0.size(), 2);
    chk("t6_a0", got0[0], ew(80, 0));
    chk("t6_a1", got0[1], ew(81, 1));
    chk("t6_b_cnt", got1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
